// File: rtl/bin2bcd_seq.sv
// Purpose: sequential double-dabble binary-to-BCD converter for the seven-segment display path.
// Latency: WIDTH+1 edges from accepted start to done; one conversion per WIDTH+1 cycles.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, not queued.
//
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   start, bin   - conversion request and the binary value captured with it
//   busy, done   - conversion in progress / one-cycle result-update pulse
//   bcd, blank   - packed BCD result (digit 0 in [3:0]) and leading-zero mask, held between conversions
module bin2bcd_seq #(
    parameter int WIDTH  = 17,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]     LAST      = CW'(WIDTH - 1);
    // Reset display shows a single "0": every digit but digit 0 blanked.
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     sreg;
    logic [4*DIGITS-1:0]  scratch;
    logic [CW-1:0]        cnt;

    logic [4*DIGITS-1:0]  adj;
    logic [4*DIGITS-1:0]  scratch_nxt;
    logic [WIDTH-1:0]     sreg_nxt;
    logic [DIGITS-1:0]    mask_nxt;
    logic                 hi_zero;

    // One double-dabble iteration: add-3 correction on every digit >= 5, then
    // shift the whole {scratch, shift register} left by one. The bit shifted
    // out of the top digit is always zero because 10^DIGITS > 2^WIDTH - 1.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        {scratch_nxt, sreg_nxt} = {adj, sreg} << 1;
    end

    // Leading-zero mask of the final result: a digit is blanked while it and
    // every digit above it are zero. Digit 0 always shows.
    always_comb begin
        hi_zero  = 1'b1;
        mask_nxt = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero     = hi_zero & (scratch_nxt[4*i +: 4] == 4'd0);
            mask_nxt[i] = hi_zero;
        end
        mask_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            blank   <= BLANK_RST;
            sreg    <= '0;
            scratch <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg    <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    sreg    <= sreg_nxt;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Last bit shifted in: publish result and return to IDLE,
                        // so done and busy never overlap.
                        bcd   <= scratch_nxt;
                        blank <= mask_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed vector table, randomized values against a
// decimal reference model, and hand-written multi-cycle corner sequences.
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [16:0] bin;
    logic        busy;
    logic        done;
    logic [23:0] bcd;
    logic [5:0]  blank;

    int ncmp = 0;
    int nbad = 0;

    bin2bcd_seq #(.WIDTH(17), .DIGITS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] v;
        logic [23:0] exp_bcd;
        logic [5:0]  exp_blank;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Decimal reference: digits by repeated division.
    function automatic logic [23:0] ref_bcd(input int v);
        logic [23:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference blanking: digits at or above the number's decimal length are blank.
    function automatic logic [5:0] ref_blank(input int v);
        int nd;
        logic [5:0] m;
        nd = 1;
        for (int p = 10; p <= v; p = p * 10) nd++;
        m = '0;
        for (int i = 0; i < 6; i++) m[i] = (i >= nd);
        return m;
    endfunction

    // Single conversion with timing checks. Sampling happens on falling edges;
    // k counts falling edges after the accepting rising edge E0 (k=17 is after E17).
    task automatic run_conv(input string tag, input logic [16:0] v,
                            input logic [23:0] eb, input logic [5:0] el);
        int k;
        int busy_n;
        bit seen;
        bit overlap;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        bin   = 17'($urandom);   // changing bin while busy must not matter
        k = 0; busy_n = 0; seen = 1'b0; overlap = 1'b0;
        while (!seen && k < 40) begin
            if (busy && done) overlap = 1'b1;
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_n++;
                @(negedge clk);
                k++;
            end
        end
        chk({tag, "_latency"}, seen ? k : -1, 17);
        chk({tag, "_bcd"}, bcd, eb);
        chk({tag, "_blank"}, blank, el);
        chk({tag, "_busy_cycles"}, busy_n, 17);
        chk({tag, "_overlap"}, overlap, 0);
        @(negedge clk);
        chk({tag, "_done_width"}, done, 0);
    endtask

    initial begin
        vec_t tbl[7];
        int k;
        int d1, d2, ndone, first;
        logic b18;
        logic [16:0] rv;

        tbl[0] = '{17'd0,      24'h000000, 6'b111110};
        tbl[1] = '{17'h1FFFF,  24'h131071, 6'b000000};
        tbl[2] = '{17'd99999,  24'h099999, 6'b100000};
        tbl[3] = '{17'd10,     24'h000010, 6'b111100};
        tbl[4] = '{17'd100000, 24'h100000, 6'b000000};
        tbl[5] = '{17'd7,      24'h000007, 6'b111110};
        tbl[6] = '{17'd1000,   24'h001000, 6'b110000};

        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 24'h000000);
        chk("rst_blank", blank, 6'b111110);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_conv($sformatf("vec%0d", i), tbl[i].v, tbl[i].exp_bcd, tbl[i].exp_blank);

        // Same value again: still a full conversion with a done pulse.
        run_conv("repeat", 17'd10, 24'h000010, 6'b111100);

        for (int i = 0; i < 20; i++) begin
            rv = 17'($urandom_range(0, 131071));
            run_conv($sformatf("rand%0d", i), rv, ref_bcd(int'(rv)), ref_blank(int'(rv)));
        end

        // Start while busy: second request at E5 is dropped.
        @(negedge clk);
        start = 1'b1; bin = 17'd5;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first = -1;
        for (k = 0; k < 60; k++) begin
            if (k == 4) begin start = 1'b1; bin = 17'd77; end
            if (k == 5) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    chk("busy_start_bcd", bcd, 24'h000005);
                end
            end
            @(negedge clk);
        end
        chk("busy_start_latency", first, 17);
        chk("busy_start_ndone", ndone, 1);

        // Reset mid-conversion at E9.
        @(negedge clk);
        start = 1'b1; bin = 17'd12345;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (k = 0; k < 40; k++) begin
            if (k == 8) reset = 1'b1;
            if (k == 9) begin
                reset = 1'b0;
                chk("midrst_busy", busy, 0);
                chk("midrst_bcd", bcd, 24'h000000);
                chk("midrst_blank", blank, 6'b111110);
            end
            if (done) ndone++;
            @(negedge clk);
        end
        chk("midrst_ndone", ndone, 0);
        run_conv("after_rst", 17'd42, 24'h000042, 6'b111100);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1; bin = 17'd1;
        @(negedge clk);
        k = 0; d1 = -1; d2 = -1; b18 = 1'b0;
        while (k < 60 && d2 < 0) begin
            if (k == 16) bin = 17'd2;
            if (k == 18) b18 = busy;
            if (done) begin
                if (d1 < 0) begin
                    d1 = k;
                    chk("b2b_bcd1", bcd, 24'h000001);
                end else begin
                    d2 = k;
                    chk("b2b_bcd2", bcd, 24'h000002);
                end
            end
            if (d2 < 0) begin
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        chk("b2b_done1_edge", d1, 17);
        chk("b2b_busy_e18", b18, 1);
        chk("b2b_done2_edge", d2, 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
